// File: rtl/riscv_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arb_state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam int          MAX_DM_STREAK_DEF  = 4;
  localparam int          TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Per-transaction watchdog: cleared while idle, counts busy cycles, flags LIMIT.
module arb_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  // expired is raised during the LIMIT-th busy cycle so the arbiter can abort on that edge
  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (load)            cnt <= '0;
    else if (en && !expired)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data, data-first with a fetch anti-starvation limit.
// Define ARB_TIMEOUT_EN to abort transactions that never see mem_ack (returns a NOP and pulses err).
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int MAX_DM_STREAK  = MAX_DM_STREAK_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        err
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_t    state, state_nx;
  logic [SW-1:0] streak;
  logic          grant_if, grant_dm, busy, tmo, finish, streak_max;

  assign busy        = (state != IDLE);
  assign streak_max  = (streak == SW'(MAX_DM_STREAK));
  assign finish      = busy & (mem_ack | tmo);
  assign stall_fetch = if_req & ~if_done;
  assign stall_mem   = dm_req & ~dm_done;

`ifdef ARB_TIMEOUT_EN
  logic expired;

  arb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (~busy),
    .en      (busy),
    .expired (expired)
  );

  assign tmo = busy & expired & ~mem_ack;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state)
      IDLE: begin
        // fetch only overtakes a pending data request once the streak has saturated
        if (dm_req && !(if_req && streak_max)) begin
          grant_dm = 1'b1;
          state_nx = DM_BUSY;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_nx = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: if (mem_ack || tmo) state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      streak    <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= tmo;
      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (!if_req)         streak <= '0;
        else if (!streak_max) streak <= streak + 1'b1;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        streak    <= '0;
      end else if (finish) begin
        mem_req <= 1'b0;
        if (state == IF_BUSY) begin
          if_done  <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : NOP_INSTR;
        end else begin
          dm_done <= 1'b1;
          // stores leave the load data register untouched
          if (!mem_ack)     dm_rdata <= NOP_INSTR;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory requests and read data, monitors compare.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_req, mem_we, stall_fetch, stall_mem, err;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  mem_exp_t    mq[$];
  rd_exp_t     ifq[$], dmq[$];
  logic [31:0] rdq[$];
  int  ack_dly = 0;
  bit  rsp_en = 1'b1;
  int  lat_a, lat_b, n;
  int  dlat[6] = '{2, 2, 2, 2, 4, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_if(input int max, output int lat);
    lat = 0;
    forever begin
      @(negedge clk); lat++;
      if (if_done) begin chk("stall_fetch_at_done", stall_fetch, 0); return; end
      chk("stall_fetch", stall_fetch, 1);
      if (lat >= max) begin
        checks++; errors++;
        $display("FAIL if_done_wait: none within %0d cycles", max);
        return;
      end
    end
  endtask

  task automatic wait_dm(input int max, output int lat);
    lat = 0;
    forever begin
      @(negedge clk); lat++;
      if (dm_done) begin chk("stall_mem_at_done", stall_mem, 0); return; end
      chk("stall_mem", stall_mem, 1);
      if (lat >= max) begin
        checks++; errors++;
        $display("FAIL dm_done_wait: none within %0d cycles", max);
        return;
      end
    end
  endtask

  // memory model: acks ack_dly cycles after mem_req is seen, read data taken in grant order
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (rsp_en) begin
        mem_ack = 1'b0;
        if (mem_req && rst_n) begin
          if (wcnt >= ack_dly) begin
            mem_ack = 1'b1;
            wcnt = 0;
            if (!mem_we && rdq.size() > 0) mem_rdata = rdq.pop_front();
            else                           mem_rdata = 32'hDEAD_BEEF;
          end else wcnt++;
        end else wcnt = 0;
      end
    end
  end

  // request monitor: checks each new mem_req against the expected grant order, then that it holds
  initial begin
    mem_exp_t cur = '{1'b0, 4'h0, 32'h0, 32'h0};
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_grant: unexpected request addr %h", mem_addr);
        end else begin
          cur = mq.pop_front();
          chk("mem_we", mem_we, cur.we);
          chk("mem_be", mem_be, cur.be);
          chk("mem_addr", mem_addr, cur.addr);
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) begin
        chk("mem_addr_hold", mem_addr, cur.addr);
      end
      prev = mem_req;
    end
  end

  // completion monitor
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (if_done) begin
        if (ifq.size() == 0) begin
          checks++; errors++; $display("FAIL if_done: unexpected pulse, if_rdata %h", if_rdata);
        end else begin
          e = ifq.pop_front();
          chk("if_rdata", if_rdata, e.data);
          chk("if_err", err, e.err);
        end
      end
      if (dm_done) begin
        if (dmq.size() == 0) begin
          checks++; errors++; $display("FAIL dm_done: unexpected pulse, dm_rdata %h", dm_rdata);
        end else begin
          e = dmq.pop_front();
          chk("dm_rdata", dm_rdata, e.data);
          chk("dm_err", err, e.err);
        end
      end
      if (err && !if_done && !dm_done) begin
        checks++; errors++; $display("FAIL err_stray: err high %b without done", err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fetch only, minimum latency
    mq.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
    rdq.push_back(32'h0050_0093);
    ifq.push_back('{32'h0050_0093, 1'b0});
    if_addr = 32'h100; if_req = 1'b1;
    wait_if(20, lat_a);
    if_req = 1'b0;
    chk("fetch_latency", lat_a, 2);

    // store with 3-cycle ack; load data register must keep its reset value
    ack_dly = 2;
    mq.push_back('{1'b1, 4'b0011, 32'h2000, 32'hCAFE_BABE});
    dmq.push_back('{32'h0, 1'b0});
    dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hCAFE_BABE; dm_req = 1'b1;
    wait_dm(20, lat_a);
    dm_req = 1'b0; dm_we = 1'b0;
    chk("store_latency", lat_a, 4);
    chk("if_rdata_hold", if_rdata, 32'h0050_0093);
    ack_dly = 0;

    // contention: data first, fetch after the idle cycle
    mq.push_back('{1'b0, 4'hF, 32'h2004, 32'h0});
    mq.push_back('{1'b0, 4'hF, 32'h108, 32'h0});
    rdq.push_back(32'h1111_2222);
    rdq.push_back(32'h0010_0073);
    dmq.push_back('{32'h1111_2222, 1'b0});
    ifq.push_back('{32'h0010_0073, 1'b0});
    dm_be = 4'hF; dm_addr = 32'h2004; dm_req = 1'b1;
    if_addr = 32'h108; if_req = 1'b1;
    fork
      begin wait_dm(20, lat_a); dm_req = 1'b0; end
      begin wait_if(20, lat_b); if_req = 1'b0; end
    join
    chk("contention_dm_latency", lat_a, 2);
    chk("contention_if_latency", lat_b, 4);

    // starvation: back-to-back loads with fetch waiting, fetch wins after four data grants
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        mq.push_back('{1'b0, 4'hF, 32'h10C, 32'h0});
        rdq.push_back(32'h0000_0513);
      end
      mq.push_back('{1'b0, 4'hF, 32'h4000 + 32'(4 * k), 32'h0});
      rdq.push_back(32'hD000_0000 + 32'(k));
      dmq.push_back('{32'hD000_0000 + 32'(k), 1'b0});
    end
    ifq.push_back('{32'h0000_0513, 1'b0});
    dm_addr = 32'h4000; dm_req = 1'b1;
    if_addr = 32'h10C; if_req = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          wait_dm(30, lat_a);
          chk("starve_dm_latency", lat_a, dlat[k]);
          if (k < 5) dm_addr = 32'h4000 + 32'(4 * (k + 1));
          else       dm_req = 1'b0;
        end
      end
      begin wait_if(40, lat_b); if_req = 1'b0; end
    join
    chk("starve_if_latency", lat_b, 10);

`ifdef ARB_TIMEOUT_EN
    // fetch never acknowledged: abort after 8 busy cycles with a NOP
    rsp_en = 1'b0; mem_ack = 1'b0;
    mq.push_back('{1'b0, 4'hF, 32'h200, 32'h0});
    ifq.push_back('{32'h0000_0013, 1'b1});
    if_addr = 32'h200; if_req = 1'b1;
    wait_if(30, lat_a);
    if_req = 1'b0;
    chk("timeout_latency", lat_a, 9);
    chk("timeout_mem_req", mem_req, 0);
    rsp_en = 1'b1;
`endif

    // reset mid-transaction, then a late ack that must be ignored
    rsp_en = 1'b0; mem_ack = 1'b0;
    mq.push_back('{1'b0, 4'hF, 32'h3000, 32'h0});
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h3000; dm_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    chk("rst_mid_granted", mem_req, 1);
    #2 rst_n = 1'b0; dm_req = 1'b0;
    #1 chk("rst_mid_mem_req", mem_req, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk); mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_mem_req", mem_req, 0);
      chk("late_ack_dm_done", dm_done, 0);
    end
    chk("late_ack_dm_rdata", dm_rdata, 32'h0);
    rsp_en = 1'b1;

    // arbiter must be back in IDLE: a plain fetch completes at minimum latency
    mq.push_back('{1'b0, 4'hF, 32'h104, 32'h0});
    rdq.push_back(32'h00A0_0113);
    ifq.push_back('{32'h00A0_0113, 1'b0});
    if_addr = 32'h104; if_req = 1'b1;
    wait_if(20, lat_a);
    if_req = 1'b0;
    chk("post_reset_fetch_latency", lat_a, 2);

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", mq.size(), 0);
    chk("rdata_queue_drained", rdq.size(), 0);
    chk("if_queue_drained", ifq.size(), 0);
    chk("dm_queue_drained", dmq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the fetch stage (instruction reads) and the MEM stage (loads/stores).
- Grants one requester at a time and sequences a req/ack transaction with the memory.
- Returns read data and a done pulse to the winner, and drives stall signals that the control unit turns into pipeline bubbles.
- Data side has priority, with an anti-starvation limit for fetch.

Parameters:
- MAX_DM_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win.
- TIMEOUT_CYCLES, 64, cycles a granted transaction may wait for mem_ack (only used with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request, level, held until if_done.
- if_addr  in  32  fetch address, stable while if_req is high.
- if_rdata  out  32  instruction word, valid when if_done is high, held until the next if_done.
- if_done  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request, level, held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data, valid when dm_done is high, held until the next dm_done.
- dm_done  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.
- stall_fetch  out  1  combinational: if_req & ~if_done.
- stall_mem  out  1  combinational: dm_req & ~dm_done.
- err  out  1  one-cycle pulse on timeout; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_done, dm_done, err = 0.
  - mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - if_rdata = 0, dm_rdata = 0, streak counter = 0.
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE:
  - dm_req only → DM_BUSY.
  - if_req only → IF_BUSY.
  - Both high → DM_BUSY, unless streak == MAX_DM_STREAK, in which case → IF_BUSY.
  - Neither → stay in IDLE.
  - On the grant edge, mem_* outputs are registered from the winner's inputs (mem_we = 0 and mem_be = 4'hF for fetch).
- IF_BUSY / DM_BUSY:
  - mem_req = 1 and mem_* are held constant.
  - On a mem_ack edge: capture mem_rdata into the winner's rdata register (stores capture nothing), pulse the winner's done for the next cycle, drop mem_req, return to IDLE.
  - Minimum latency: req sampled at edge 0, mem_req high in cycle 1, ack in cycle 1, done in cycle 2.
- Mandatory IDLE cycle after each transaction: the requester sees done during it and must drop req or present a new address. req still high on the following edge is a new request.
- Streak counter:
  - Increments on a DM grant made while if_req is high; saturates at MAX_DM_STREAK.
  - Clears on any IF grant, and on a DM grant made while if_req is low.
- mem_ack in IDLE is ignored.
- Simultaneous req rise and done in the same cycle are legal.
- Reset asserted mid-transaction:
  - Immediately drops mem_req and returns to IDLE; no done is issued.
  - A late mem_ack after reset is ignored.
- stall_* are purely combinational and carry no registered delay.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A per-transaction counter loads 0 at grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, pulse the winner's done and err for one cycle, set the winner's rdata = 32'h0000_0013 (NOP), return to IDLE.
- Undefined: no counter; BUSY waits for mem_ack indefinitely; err = 0.

Decomposition:
- Package riscv_arb_pkg holds:
  - Enum arb_state_t {IDLE, IF_BUSY, DM_BUSY}.
  - Localparam NOP_INSTR = 32'h0000_0013.
  - Default MAX_DM_STREAK and TIMEOUT_CYCLES.
- Optional sub-module arb_timeout_ctr: counter with load/enable and an expired flag, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, memory acks 1 cycle after mem_req with 0x00500093 → mem_addr=0x100, mem_we=0; if_done pulses 2 cycles after the request edge; if_rdata=0x00500093; stall_fetch=1 until then.
- Store: dm_req=1, dm_we=1, dm_be=4'b0011, dm_addr=0x2000, dm_wdata=0xCAFEBABE, ack after 3 cycles → mem_* carries these values unchanged while mem_req is high; dm_done pulses once; if_rdata unchanged.
- Contention: if_req and dm_req rise on the same edge → DM granted first; IF granted on the edge after the IDLE cycle; mem_addr sequence is dm_addr then if_addr.
- Starvation: dm_req held high for 6 back-to-back loads with if_req high, MAX_DM_STREAK=4 → grant order D,D,D,D,I,D; streak returns to 0 after the I grant.
- Reset mid-transaction: rst_n low for 1 cycle while in DM_BUSY; ack arrives 2 cycles later → mem_req=0 immediately; no dm_done; state IDLE; the late ack is ignored.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, fetch, no ack → mem_req drops after 8 BUSY cycles; if_done=1 and err=1 for one cycle; if_rdata=0x00000013.
